pool_tile_loader: RTL and testbench

Upstream feeder for the final pooling stage. Accepts a raster-order pixel stream over a valid/ready handshake and assembles one 8x8 tile of 8-bit pixels. It presents the completed tile as a flat bus, using the same row-major layout the pooling stage indexes as matrix[r][c]. The tile is held stable until the downstream consumer accepts it.

---
 rtl/pool_tile_loader.sv | 169 ++++++++++++++++
 tb/tb_pool_tile_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool_tile_loader.sv
// Pool tile loader: packs a raster-order pixel stream into an NxN tile for the pooling stage.
// Optional two-bank build: define POOL_TILE_PINGPONG_EN to keep filling while a tile is held.

module pool_tile_bank #(
    parameter int DATA_W = 8,
    parameter int N      = 8,
    parameter int IDX_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_W-1:0]     din,
    output logic [N*N*DATA_W-1:0] dout
);
    logic [N*N-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst)
            mem <= '0;
        else if (we)
            mem[idx] <= din;
    end

    assign dout = mem;
endmodule

module pool_tile_loader #(
    parameter int DATA_W  = 8,
    parameter int N       = 8,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(N*N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     pix_in,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    output logic                  pix_ready,
    output logic [N*N*DATA_W-1:0] tile_out,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic [CNT_W-1:0]      tile_count,
    output logic [IDX_W-1:0]      wr_idx
);
    localparam int NPIX = N * N;
    localparam int TW   = NPIX * DATA_W;

`ifdef POOL_TILE_PINGPONG_EN
    localparam int NB = 2;
    // HOLD: one bank presented while the other fills; BOTH: both banks full
    typedef enum logic [1:0] {FILL, HOLD, BOTH} state_t;
`else
    localparam int NB = 1;
    typedef enum logic {FILL, HOLD} state_t;
`endif

    state_t                 state, state_n;
    logic [IDX_W-1:0]       wr_idx_n;
    logic [CNT_W-1:0]       tile_count_n;
    logic                   pix_ready_n, tile_valid_n;
    logic                   accept, take, complete;
    logic [IDX_W-1:0]       wr_pos;
    logic [NB-1:0]          bank_we;
    logic [NB-1:0][TW-1:0]  bank_dout;
    logic [TW-1:0]          sel_tile;

    assign accept   = pix_valid && pix_ready;
    assign take     = tile_valid && tile_ready;
    // a start-of-tile beat restarts the tile, so it can never finish one
    assign complete = accept && !pix_sof && (wr_idx == IDX_W'(NPIX-1));
    assign wr_pos   = pix_sof ? '0 : wr_idx;

`ifdef POOL_TILE_PINGPONG_EN
    logic wr_bank, rd_bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (complete) wr_bank <= ~wr_bank;
            if (take)     rd_bank <= ~rd_bank;
        end
    end

    assign bank_we  = {accept && wr_bank, accept && !wr_bank};
    assign sel_tile = bank_dout[rd_bank];
`else
    assign bank_we  = accept;
    assign sel_tile = bank_dout[0];
`endif

    generate
        for (genvar b = 0; b < NB; b++) begin : g_bank
            pool_tile_bank #(
                .DATA_W (DATA_W),
                .N      (N),
                .IDX_W  (IDX_W)
            ) u_bank (
                .clk  (clk),
                .rst  (rst),
                .we   (bank_we[b]),
                .idx  (wr_pos),
                .din  (pix_in),
                .dout (bank_dout[b])
            );
        end
    endgenerate

    // Gating keeps the bus at zero (and stable) whenever no tile is offered
    assign tile_out = sel_tile & {TW{tile_valid}};

    always_comb begin
        state_n      = state;
        wr_idx_n     = wr_idx;
        tile_count_n = tile_count;
        if (accept) begin
            if (pix_sof)
                wr_idx_n = IDX_W'(1);
            else if (complete)
                wr_idx_n = '0;
            else
                wr_idx_n = wr_idx + IDX_W'(1);
        end
        if (take)
            tile_count_n = tile_count + CNT_W'(1);
        case (state)
            FILL: if (complete) state_n = HOLD;
            HOLD: begin
`ifdef POOL_TILE_PINGPONG_EN
                if (complete && !take)
                    state_n = BOTH;
                else if (take && !complete)
                    state_n = FILL;
`else
                if (take)
                    state_n = FILL;
`endif
            end
`ifdef POOL_TILE_PINGPONG_EN
            BOTH: if (take) state_n = HOLD;
`endif
            default: state_n = FILL;
        endcase
`ifdef POOL_TILE_PINGPONG_EN
        pix_ready_n  = (state_n != BOTH);
`else
        pix_ready_n  = (state_n == FILL);
`endif
        tile_valid_n = (state_n != FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FILL;
            wr_idx     <= '0;
            tile_count <= '0;
            pix_ready  <= 1'b1;
            tile_valid <= 1'b0;
        end else begin
            state      <= state_n;
            wr_idx     <= wr_idx_n;
            tile_count <= tile_count_n;
            pix_ready  <= pix_ready_n;
            tile_valid <= tile_valid_n;
        end
    end
endmodule

// File: tb/tb_pool_tile_loader.sv
// Bench for pool_tile_loader: directed and random pixel streams scored against a tile-queue model.
// Runs with CNT_W=2 so the tile counter wraps within a short run.

module tb_pool_tile_loader;
    localparam int DATA_W = 8;
    localparam int N      = 8;
    localparam int CNT_W  = 2;
    localparam int NPIX   = N * N;
    localparam int IDX_W  = $clog2(NPIX);
    localparam int TW     = NPIX * DATA_W;
`ifdef POOL_TILE_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [TW-1:0] tile_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid, pix_sof, pix_ready;
    logic [TW-1:0]     tile_out;
    logic              tile_valid, tile_ready;
    logic [CNT_W-1:0]  tile_count;
    logic [IDX_W-1:0]  wr_idx;

    pool_tile_loader #(.DATA_W(DATA_W), .N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_ready  (pix_ready),
        .tile_out   (tile_out),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_count (tile_count),
        .wr_idx     (wr_idx)
    );

    always #5 clk = ~clk;

    // Model: pixels since the last tile boundary, full tiles awaiting hand-off, handed-off count
    logic [DATA_W-1:0] partial[$];
    tile_t             held[$];
    logic [CNT_W-1:0]  m_cnt;
    int                vectors = 0;
    int                miscompares = 0;

    task automatic chk(input string tag, input tile_t obs, input tile_t exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("pix_ready", TW'(pix_ready), TW'(held.size() < NB));
        chk("tile_valid", TW'(tile_valid), TW'(held.size() != 0));
        chk("tile_count", TW'(tile_count), TW'(m_cnt));
        chk("wr_idx", TW'(wr_idx), TW'(partial.size()));
        if (held.size() != 0)
            chk("tile_out", tile_out, held[0]);
    endtask

    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic s,
                         input logic tr, output logic acc);
        logic  tk;
        tile_t t;
        pix_valid  = v;
        pix_in     = d;
        pix_sof    = s;
        tile_ready = tr;
        acc = v && (held.size() < NB);
        tk  = tr && (held.size() != 0);
        @(posedge clk);
        #1;
        if (tk) begin
            void'(held.pop_front());
            m_cnt = m_cnt + 1'b1;
        end
        if (acc) begin
            if (s) partial.delete();
            partial.push_back(d);
            if (partial.size() == NPIX) begin
                for (int i = 0; i < NPIX; i++) t[i*DATA_W +: DATA_W] = partial[i];
                held.push_back(t);
                partial.delete();
            end
        end
        check_state();
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pix_valid  = 1'b1;
        pix_in     = 8'hAA;
        pix_sof    = 1'b0;
        tile_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        partial.delete();
        held.delete();
        m_cnt = '0;
        chk("rst_wr_idx", TW'(wr_idx), TW'(0));
        chk("rst_tile_valid", TW'(tile_valid), TW'(0));
        chk("rst_tile_count", TW'(tile_count), TW'(0));
        chk("rst_tile_out", tile_out, TW'(0));
        chk("rst_pix_ready", TW'(pix_ready), TW'(1));
    endtask

    // Producer holds each beat until it is accepted
    task automatic send_pix(input logic [DATA_W-1:0] d, input logic s);
        logic acc;
        int   tries = 0;
        do begin
            cycle(1'b1, d, s, 1'b0, acc);
            tries++;
        end while (!acc && tries < 100);
        vectors++;
        assert (acc)
        else begin
            miscompares++;
            $error("FAIL send_timeout: observed accepted=%0b expected 1", acc);
        end
    endtask

    task automatic send_tile(input int base, input bit gaps);
        logic acc;
        for (int i = 0; i < NPIX; i++) begin
            if (gaps && (i % 3 == 2)) cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
            send_pix(8'(base + i), i == 0);
        end
    endtask

    task automatic take_tile();
        logic acc;
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    initial begin
        logic acc;
        logic [CNT_W-1:0] wrap_seq [5];
        wrap_seq = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        m_cnt = '0;
        do_reset();
        do_reset();

        // Basic fill with the consumer stalled
        send_tile(0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, acc);
        chk("basic_valid", TW'(tile_valid), TW'(1));
        chk("elem_3_5", TW'(tile_out[(3*N+5)*DATA_W +: DATA_W]), TW'(29));
        chk("elem_7_7", TW'(tile_out[(7*N+7)*DATA_W +: DATA_W]), TW'(63));
        chk("elem_0_7", TW'(tile_out[7*DATA_W +: DATA_W]), TW'(7));
`ifndef POOL_TILE_PINGPONG_EN
        chk("hold_stall", TW'(pix_ready), TW'(0));
`endif
        take_tile();
        chk("basic_count", TW'(tile_count), TW'(1));
        chk("basic_after_valid", TW'(tile_valid), TW'(0));
        chk("basic_after_ready", TW'(pix_ready), TW'(1));

        // Bubbles every third cycle
        send_tile(100, 1'b1);
        chk("bubble_elem_63", TW'(tile_out[63*DATA_W +: DATA_W]), TW'(163));
        take_tile();

        // Resync: partial tile of 0xFF, then a fresh start-of-tile
        for (int i = 0; i < 20; i++) send_pix(8'hFF, 1'b0);
        send_tile(0, 1'b0);
        chk("resync_elem_19", TW'(tile_out[19*DATA_W +: DATA_W]), TW'(19));
        take_tile();
        chk("resync_count", TW'(tile_count), TW'(3));
        take_tile();
        chk("resync_count_once", TW'(tile_count), TW'(3));

        // Reset in the middle of a fill
        for (int i = 0; i < 40; i++) send_pix(8'(200 + i), i == 0);
        do_reset();
        send_tile(0, 1'b0);
        take_tile();
        chk("post_rst_count", TW'(tile_count), TW'(1));

        // Counter wrap with random tile contents
        for (int k = 0; k < 5; k++) begin
            send_tile(int'($urandom_range(0, 255)), 1'b0);
            take_tile();
            chk("wrap_count", TW'(tile_count), TW'(wrap_seq[k]));
        end

        // Random traffic: bubbles, stalls, stray start-of-tile beats, ignored beats
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 99) == 0,
                  1'($urandom_range(0, 1)), acc);

`ifdef POOL_TILE_PINGPONG_EN
        // Continuous streaming into both banks with an always-ready consumer
        do_reset();
        for (int i = 0; i < 3 * NPIX; i++) begin
            cycle(1'b1, 8'(i), i == 0, 1'b1, acc);
            chk("pp_no_stall", TW'(acc), TW'(1));
            if (i == NPIX - 1 || i == 2 * NPIX - 1)
                chk("pp_tile_valid", TW'(tile_valid), TW'(1));
        end
        chk("pp_last_valid", TW'(tile_valid), TW'(1));
        take_tile();
        chk("pp_count", TW'(tile_count), TW'(3));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed run still active expected finished");
        $fatal(1, "bench time limit expired");
    end
endmodule
